// File: rtl/dma_pkg.sv
// Shared types for the DMA command controller: FSM states,
// DMA progress flag indices and the status word layout.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ACK   = 3'd3,
      ST_FAULT = 3'd4
   } state_e;

   localparam int VALID_LOAD  = 1;
   localparam int VALID_STORE = 2;
   localparam int VALID_DONE  = 3;

   typedef struct packed {
      logic timeout;
      logic store_ok;
      logic load_ok;
   } stat_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor FIFO with wrap-bit pointers; push and pop are
// ignored when full or empty respectively.
module dma_desc_fifo #(
   parameter int WIDTH = 160,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                    (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign data_o  = mem_q[rd_q[AW-1:0]];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/dma_cmd_ctrl.sv
// Queues DMA descriptors and sequences them onto a register-style
// DMA command interface, returning one status word per transfer.
module dma_cmd_ctrl
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  desc_valid_i,
   output logic                  desc_ready_o,
   input  logic [DATA_WIDTH-1:0] desc_length_i,
   input  logic [63:0]           desc_src_i,
   input  logic [63:0]           desc_dst_i,
   output logic [DATA_WIDTH-1:0] start_o,
   output logic [DATA_WIDTH-1:0] length_o,
   output logic [DATA_WIDTH-1:0] source_addr_lsb_o,
   output logic [DATA_WIDTH-1:0] source_addr_msb_o,
   output logic [DATA_WIDTH-1:0] dest_addr_lsb_o,
   output logic [DATA_WIDTH-1:0] dest_addr_msb_o,
   input  logic [DATA_WIDTH-1:0] valid_i,
   output logic [DATA_WIDTH-1:0] done_o,
   output logic                  stat_valid_o,
   input  logic                  stat_ready_i,
   output logic [2:0]            stat_o,
   output logic                  busy_o,
   output logic                  fault_o
);

   localparam int DW = DATA_WIDTH + 128;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   state_e          state_q, state_d;
   logic [DW-1:0]   cmd_q, cmd_d, head;
   logic [CW-1:0]   cnt_q, cnt_d;
   stat_t           stat_q, stat_d;
   logic            stv_q, stv_d;
   logic            fault_q, fault_d;
   logic            full, empty, push, pop;

   assign desc_ready_o = !full && !fault_q;
   assign push         = desc_valid_i && desc_ready_o;

   dma_desc_fifo #(
      .WIDTH (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  ({desc_length_i, desc_src_i, desc_dst_i}),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      stat_d  = stat_q;
      stv_d   = stv_q;
      fault_d = fault_q;
      pop     = 1'b0;
      if (stv_q && stat_ready_i) stv_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!empty && !stv_q) begin
               pop     = 1'b1;
               cmd_d   = head;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (valid_i[VALID_DONE] && !stv_q) begin
               stat_d.timeout  = 1'b0;
               stat_d.store_ok = valid_i[VALID_STORE];
               stat_d.load_ok  = valid_i[VALID_LOAD];
               stv_d   = 1'b1;
               state_d = ST_ACK;
            end else if (!valid_i[VALID_DONE] &&
                         cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               stat_d  = 3'b100;
               stv_d   = 1'b1;
               fault_d = 1'b1;
               state_d = ST_FAULT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACK: begin
            if (valid_i == '0) state_d = ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         cnt_q   <= '0;
         stat_q  <= '0;
         stv_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         stat_q  <= stat_d;
         stv_q   <= stv_d;
         fault_q <= fault_d;
      end
   end

   // Command layout in the FIFO word: {length, src, dst}
   assign length_o          = cmd_q[DW-1:128];
   assign source_addr_lsb_o = DATA_WIDTH'(cmd_q[95:64]);
   assign source_addr_msb_o = DATA_WIDTH'(cmd_q[127:96]);
   assign dest_addr_lsb_o   = DATA_WIDTH'(cmd_q[31:0]);
   assign dest_addr_msb_o   = DATA_WIDTH'(cmd_q[63:32]);

   assign start_o = DATA_WIDTH'(state_q == ST_ISSUE ||
                                state_q == ST_WAIT);
   assign done_o  = DATA_WIDTH'(state_q == ST_ACK);

   assign stat_valid_o = stv_q;
   assign stat_o       = stat_q;
   assign fault_o      = fault_q;
   assign busy_o       = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_dma_cmd_ctrl.sv
// Directed bench for dma_cmd_ctrl: cycle table for the basic and
// store-denied transfers, then FIFO-full, reset-in-ACK and timeout.
module tb_dma_cmd_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        desc_valid_i;
   logic        desc_ready_o;
   logic [31:0] desc_length_i;
   logic [63:0] desc_src_i;
   logic [63:0] desc_dst_i;
   logic [31:0] start_o, length_o;
   logic [31:0] source_addr_lsb_o, source_addr_msb_o;
   logic [31:0] dest_addr_lsb_o, dest_addr_msb_o;
   logic [31:0] valid_i;
   logic [31:0] done_o;
   logic        stat_valid_o;
   logic        stat_ready_i;
   logic [2:0]  stat_o;
   logic        busy_o;
   logic        fault_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   dma_cmd_ctrl #(
      .DATA_WIDTH     (32),
      .DEPTH          (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .desc_valid_i      (desc_valid_i),
      .desc_ready_o      (desc_ready_o),
      .desc_length_i     (desc_length_i),
      .desc_src_i        (desc_src_i),
      .desc_dst_i        (desc_dst_i),
      .start_o           (start_o),
      .length_o          (length_o),
      .source_addr_lsb_o (source_addr_lsb_o),
      .source_addr_msb_o (source_addr_msb_o),
      .dest_addr_lsb_o   (dest_addr_lsb_o),
      .dest_addr_msb_o   (dest_addr_msb_o),
      .valid_i           (valid_i),
      .done_o            (done_o),
      .stat_valid_o      (stat_valid_o),
      .stat_ready_i      (stat_ready_i),
      .stat_o            (stat_o),
      .busy_o            (busy_o),
      .fault_o           (fault_o)
   );

   typedef struct {
      logic        dv;
      logic [31:0] len;
      logic [63:0] src, dst;
      logic [31:0] vin;
      logic        sr;
      logic        rdy, st, dn, sv;
      logic [2:0]  stat;
      logic        bsy, flt;
      logic [31:0] elen;
      logic [63:0] esrc, edst;
   } vec_t;

   localparam logic [31:0] L1 = 32'd3;
   localparam logic [63:0] S1 = 64'h0000_0000_8000_0000;
   localparam logic [63:0] T1 = 64'h0000_0001_0000_2000;
   localparam logic [31:0] L2 = 32'd7;
   localparam logic [63:0] S2 = 64'h0000_0012_3456_7890;
   localparam logic [63:0] T2 = 64'hAAAA_BBBB_CCCC_DDDD;
   localparam logic [31:0] L3 = 32'd1;
   localparam logic [63:0] S3 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] T3 = 64'h5555_6666_7777_8888;

   function automatic vec_t mk(
      input logic dv, input logic [31:0] len,
      input logic [63:0] src, input logic [63:0] dst,
      input logic [31:0] vin, input logic sr,
      input logic rdy, input logic st, input logic dn,
      input logic sv, input logic [2:0] stat,
      input logic bsy, input logic flt,
      input logic [31:0] elen,
      input logic [63:0] esrc, input logic [63:0] edst);
      vec_t v;
      v.dv = dv; v.len = len; v.src = src; v.dst = dst;
      v.vin = vin; v.sr = sr; v.rdy = rdy; v.st = st;
      v.dn = dn; v.sv = sv; v.stat = stat; v.bsy = bsy;
      v.flt = flt; v.elen = elen; v.esrc = esrc; v.edst = edst;
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      desc_valid_i  = 1'b0;
      desc_length_i = '0;
      desc_src_i    = '0;
      desc_dst_i    = '0;
      valid_i       = '0;
      stat_ready_i  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      cyc();
      cyc();
      rst_ni = 1'b1;
   endtask

   task automatic push_desc(input logic [31:0] l, input logic [63:0] s,
                            input logic [63:0] d);
      desc_valid_i  = 1'b1;
      desc_length_i = l;
      desc_src_i    = s;
      desc_dst_i    = d;
   endtask

   task automatic wait_start(input string nm);
      int t = 0;
      while (start_o !== 32'd1 && t < 40) begin
         cyc();
         t++;
      end
      chk(nm, start_o, 1);
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (done_o !== 32'd1 && t < 40) begin
         cyc();
         t++;
      end
      chk(nm, done_o, 1);
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back(mk(1,L1,S1,T1, 0 ,0, 1,0,0,0,3'd0,0,0, 0,0,0));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,0,0,3'd0,1,0, 0,0,0));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,1,0,0,3'd0,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    2 ,0, 1,1,0,0,3'd0,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    6 ,0, 1,1,0,0,3'd0,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    14,0, 1,1,0,0,3'd0,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    14,0, 1,0,1,1,3'd3,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,1,1,3'd3,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    0 ,1, 1,0,0,1,3'd3,0,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,0,0,3'd3,0,0, L1,S1,T1));
      tbl.push_back(mk(1,L2,S2,T2, 0 ,0, 1,0,0,0,3'd3,0,0, L1,S1,T1));
      tbl.push_back(mk(1,L3,S3,T3, 0 ,0, 1,0,0,0,3'd3,1,0, L1,S1,T1));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,1,0,0,3'd3,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    2 ,0, 1,1,0,0,3'd3,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    10,0, 1,1,0,0,3'd3,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,1,1,3'd1,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,0,1,3'd1,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,0,1,3'd1,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    0 ,1, 1,0,0,1,3'd1,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,0,0,3'd1,1,0, L2,S2,T2));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,1,0,0,3'd1,1,0, L3,S3,T3));
      tbl.push_back(mk(0,0,0,0,    8 ,0, 1,1,0,0,3'd1,1,0, L3,S3,T3));
      tbl.push_back(mk(0,0,0,0,    0 ,1, 1,0,1,1,3'd0,1,0, L3,S3,T3));
      tbl.push_back(mk(0,0,0,0,    0 ,0, 1,0,0,0,3'd0,0,0, L3,S3,T3));

      // Reset state
      do_reset();
      chk("rst_ready", desc_ready_o, 1);
      chk("rst_start", start_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_stat_valid", stat_valid_o, 0);
      chk("rst_stat", stat_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_fault", fault_o, 0);
      chk("rst_length", length_o, 0);

      // Single transfer and store-denied transfer, cycle by cycle
      foreach (tbl[i]) begin
         cyc();
         desc_valid_i  = tbl[i].dv;
         desc_length_i = tbl[i].len;
         desc_src_i    = tbl[i].src;
         desc_dst_i    = tbl[i].dst;
         valid_i       = tbl[i].vin;
         stat_ready_i  = tbl[i].sr;
         #1;
         chk($sformatf("row%0d_ready", i), desc_ready_o, tbl[i].rdy);
         chk($sformatf("row%0d_start", i), start_o, tbl[i].st);
         chk($sformatf("row%0d_done", i), done_o, tbl[i].dn);
         chk($sformatf("row%0d_sv", i), stat_valid_o, tbl[i].sv);
         chk($sformatf("row%0d_stat", i), stat_o, tbl[i].stat);
         chk($sformatf("row%0d_busy", i), busy_o, tbl[i].bsy);
         chk($sformatf("row%0d_fault", i), fault_o, tbl[i].flt);
         chk($sformatf("row%0d_len", i), length_o, tbl[i].elen);
         chk($sformatf("row%0d_src", i),
             {source_addr_msb_o, source_addr_lsb_o}, tbl[i].esrc);
         chk($sformatf("row%0d_dst", i),
             {dest_addr_msb_o, dest_addr_lsb_o}, tbl[i].edst);
      end

      // FIFO full: hold a status word pending so nothing is popped
      do_reset();
      push_desc(32'h10, 64'h10, 64'h0);
      cyc();
      desc_valid_i = 1'b0;
      valid_i = 32'h8;
      wait_done("full_pre_done");
      valid_i = 32'h0;
      cyc();
      chk("full_pre_sv", stat_valid_o, 1);
      for (int k = 0; k < 5; k++) begin
         push_desc(32'h21 + k, 64'hC0DE_0000_0000_0000 + k, 64'h0);
         #1;
         chk($sformatf("full_ready%0d", k), desc_ready_o, (k < 4));
         cyc();
      end
      desc_valid_i = 1'b0;
      chk("full_busy", busy_o, 1);
      chk("full_no_start", start_o, 0);
      stat_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_start($sformatf("drain%0d_start", k));
         chk($sformatf("drain%0d_len", k), length_o, 32'h21 + k);
         chk($sformatf("drain%0d_src", k),
             {source_addr_msb_o, source_addr_lsb_o},
             64'hC0DE_0000_0000_0000 + k);
         valid_i = 32'h8;
         wait_done($sformatf("drain%0d_done", k));
         valid_i = 32'h0;
         cyc();
      end
      cyc();
      chk("drain_busy", busy_o, 0);
      cyc();
      cyc();
      chk("drain_no_fifth", start_o, 0);
      stat_ready_i = 1'b0;

      // Reset while in ACK with a second descriptor queued
      do_reset();
      push_desc(32'h31, 64'h31, 64'h131);
      cyc();
      push_desc(32'h32, 64'h32, 64'h132);
      cyc();
      desc_valid_i = 1'b0;
      valid_i = 32'h6 | 32'h8;
      wait_done("rack_done");
      chk("rack_busy_before", busy_o, 1);
      rst_ni  = 1'b0;
      valid_i = 32'h0;
      cyc();
      rst_ni = 1'b1;
      chk("rack_start", start_o, 0);
      chk("rack_done0", done_o, 0);
      chk("rack_busy", busy_o, 0);
      chk("rack_sv", stat_valid_o, 0);
      cyc();
      cyc();
      cyc();
      chk("rack_fifo_empty", busy_o, 0);
      chk("rack_no_start", start_o, 0);

      // Timeout: valid_i stuck at zero
      do_reset();
      push_desc(32'h44, 64'h44, 64'h144);
      cyc();
      desc_valid_i = 1'b0;
      wait_start("to_start");
      for (int k = 0; k < 16; k++) cyc();
      chk("to_wait16_fault", fault_o, 0);
      chk("to_wait16_start", start_o, 1);
      cyc();
      chk("to_fault", fault_o, 1);
      chk("to_stat", stat_o, 3'b100);
      chk("to_sv", stat_valid_o, 1);
      chk("to_start0", start_o, 0);
      chk("to_done0", done_o, 0);
      chk("to_ready", desc_ready_o, 0);
      stat_ready_i = 1'b1;
      push_desc(32'h55, 64'h55, 64'h155);
      cyc();
      stat_ready_i = 1'b0;
      chk("to_sv_clr", stat_valid_o, 0);
      chk("to_fault_sticky", fault_o, 1);
      chk("to_ready_after", desc_ready_o, 0);
      cyc();
      cyc();
      chk("to_terminal_start", start_o, 0);
      chk("to_terminal_ready", desc_ready_o, 0);
      desc_valid_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dma_cmd_ctrl.md
DMA_CMD_CTRL -- requirements
Module: dma_cmd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the DMA command and status words.
REQ-002 Parameter DEPTH, default 4, power of two, SHALL set the descriptor FIFO depth.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the WAIT-state cycles before fault.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 Ports SHALL be:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
desc_valid_i  in  1  descriptor offered
desc_ready_o  out  1  descriptor accepted when high with desc_valid_i
desc_length_i  in  DATA_WIDTH  word count minus one
desc_src_i  in  64  source address
desc_dst_i  in  64  destination address
start_o  out  DATA_WIDTH  DMA start command
length_o  out  DATA_WIDTH  DMA length
source_addr_lsb_o / source_addr_msb_o  out  DATA_WIDTH each  source halves
dest_addr_lsb_o / dest_addr_msb_o  out  DATA_WIDTH each  destination halves
valid_i  in  DATA_WIDTH  DMA progress flags (bit1 load, bit2 store, bit3 done)
done_o  out  DATA_WIDTH  completion acknowledge to DMA
stat_valid_o  out  1  status word pending
stat_ready_i  in  1  status consumed
stat_o  out  3  {timeout, store_ok, load_ok}
busy_o  out  1  FSM not IDLE or FIFO non-empty
fault_o  out  1  sticky timeout fault

Function
REQ-006 FIFO push SHALL occur when desc_valid_i && desc_ready_o; desc_ready_o SHALL be 0 when the FIFO is full (including a same-cycle pop) or fault_o is 1.
REQ-007 FIFO pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ, low bits equal.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, ACK, FAULT.
REQ-009 IDLE: if FIFO non-empty and stat_valid_o is 0, pop the head into the command register and go to ISSUE; otherwise stay.
REQ-010 ISSUE/WAIT: start_o SHALL be 1 (zero-extended) and the address/length outputs SHALL be held stable from the command register; ISSUE SHALL go to WAIT after one cycle.
REQ-011 WAIT: when valid_i[3] is 1 and stat_valid_o is 0, load stat_o = {0, valid_i[2], valid_i[1]}, set stat_valid_o, and go to ACK.
REQ-012 WAIT: the timeout counter SHALL clear on WAIT entry and increment each WAIT cycle; on reaching TIMEOUT_CYCLES-1 without valid_i[3], load stat_o = 3'b100, set stat_valid_o and fault_o, and go to FAULT.
REQ-013 ACK: start_o SHALL be 0 and done_o SHALL be 1; when valid_i == 0, go to IDLE with done_o 0 the next cycle.
REQ-014 FAULT SHALL be terminal until reset; start_o and done_o SHALL be 0.
REQ-015 stat_valid_o SHALL clear on the cycle after stat_valid_o && stat_ready_i.
REQ-016 Latency: a descriptor pushed into an empty FIFO in cycle N SHALL give start_o = 1 in cycle N+2.
REQ-017 Address split: *_lsb_o = addr[31:0] and *_msb_o = addr[63:32]; length SHALL pass through unmodified.
REQ-018 All outputs not named in a state SHALL be 0 in that state, except address/length, which hold their last value.

Reset
REQ-019 While rst_ni = 0 at a clock edge, the FSM SHALL go to IDLE and the FIFO pointers, command register, counter, stat_valid_o, stat_o and fault_o SHALL go to 0.
REQ-020 A reset mid-transfer SHALL discard queued descriptors, with start_o = 0 and done_o = 0 from the first cycle after reset.

Structure
REQ-021 Package dma_pkg SHALL hold the FSM state enum, the VALID_LOAD/STORE/DONE bit indices and the stat_t struct.
REQ-022 The descriptor FIFO SHALL be the sub-module dma_desc_fifo (width 160, depth DEPTH).

Verification
REQ-023 Single descriptor: len=3, src=0x8000_0000, DMA model returns valid 0x2, then 0x6, then 0xE -> start_o=1 at N+2, stat_o=3'b011, done_o held until valid_i=0.
REQ-024 Store denied: valid_i goes 0x2 then 0xA -> stat_o=3'b001; next descriptor not issued until stat_ready_i.
REQ-025 FIFO full: push 5 descriptors with DEPTH=4 and the DMA stalled -> 5th refused (desc_ready_o=0); order preserved on drain.
REQ-026 Timeout: TIMEOUT_CYCLES=16, valid_i stuck at 0 -> stat_o=3'b100 and fault_o=1 after 16 WAIT cycles; desc_ready_o=0 thereafter.
REQ-027 Reset during ACK -> start_o=0, done_o=0, busy_o=0 on the next cycle; FIFO empty.
